// File: rtl/vdp_reg_write_arbiter_if.sv
// Register-write bus between the copper/host requesters and the VDP register-write arbiter.
interface vdp_reg_write_arbiter_if;
   logic        copper_write_en;
   logic [5:0]  copper_write_address;
   logic [15:0] copper_write_data;
   logic        copper_write_ready;

   logic        host_write_en;
   logic [5:0]  host_write_address;
   logic [15:0] host_write_data;
   logic        host_write_ready;

   logic        reg_write_en;
   logic [5:0]  reg_write_address;
   logic [15:0] reg_write_data;

   modport master (
      output copper_write_en,
      output copper_write_address,
      output copper_write_data,
      input  copper_write_ready,
      output host_write_en,
      output host_write_address,
      output host_write_data,
      input  host_write_ready,
      input  reg_write_en,
      input  reg_write_address,
      input  reg_write_data
   );

   modport slave (
      input  copper_write_en,
      input  copper_write_address,
      input  copper_write_data,
      output copper_write_ready,
      input  host_write_en,
      input  host_write_address,
      input  host_write_data,
      output host_write_ready,
      output reg_write_en,
      output reg_write_address,
      output reg_write_data
   );
endinterface

// File: rtl/vdp_reg_write_arbiter.sv
// Merges FIFO-buffered copper writes and host writes onto the single VDP register-file port.
// Optional VDP_REG_ARB_OVERFLOW_EN adds a sticky copper_overflow flag cleared by overflow_clear.
module vdp_reg_write_arbiter #(
   parameter int unsigned FIFO_DEPTH      = 4,
   parameter int unsigned MAX_HOST_STREAK = 3
) (
   input  logic                        clk,
   input  logic                        reset,
   vdp_reg_write_arbiter_if.slave      bus,
   output logic [$clog2(FIFO_DEPTH):0] copper_fifo_level
`ifdef VDP_REG_ARB_OVERFLOW_EN
   ,
   output logic                        copper_overflow,
   input  logic                        overflow_clear
`endif
);

   localparam int unsigned PtrW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CntW    = PtrW + 1;
   localparam int unsigned StreakW = (MAX_HOST_STREAK > 0) ? $clog2(MAX_HOST_STREAK + 1) : 1;
   localparam logic [CntW-1:0]    DepthCnt  = CntW'(FIFO_DEPTH);
   localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_HOST_STREAK);

   logic [5:0]         fifo_addr_q [FIFO_DEPTH];
   logic [15:0]        fifo_data_q [FIFO_DEPTH];
   logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]    count_q, count_d;
   logic [StreakW-1:0] streak_q, streak_d;

   logic               reg_en_q, reg_en_d;
   logic [5:0]         reg_addr_q, reg_addr_d;
   logic [15:0]        reg_data_q, reg_data_d;

   logic               fifo_empty;
   logic               fifo_full;
   logic               push;
   logic               pop;
   logic               force_copper;
   logic               host_grant;
   logic               copper_grant;

   // All arbitration decisions use the registered count, so a word pushed this cycle
   // can only be popped from the next cycle on.
   always_comb begin
      fifo_empty   = (count_q == '0);
      fifo_full    = (count_q == DepthCnt);
      force_copper = (streak_q == StreakMax) && !fifo_empty;
      host_grant   = bus.host_write_en && !force_copper;
      copper_grant = !host_grant && !fifo_empty;
      push         = bus.copper_write_en && !fifo_full;
      pop          = copper_grant;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      streak_d = streak_q;
      if (copper_grant || fifo_empty) begin
         streak_d = '0;
      end else if (host_grant && (streak_q != StreakMax)) begin
         streak_d = streak_q + StreakW'(1);
      end
   end

   always_comb begin
      reg_en_d   = host_grant || copper_grant;
      reg_addr_d = reg_addr_q;
      reg_data_d = reg_data_q;
      if (host_grant) begin
         reg_addr_d = bus.host_write_address;
         reg_data_d = bus.host_write_data;
      end else if (copper_grant) begin
         reg_addr_d = fifo_addr_q[rd_ptr_q];
         reg_data_d = fifo_data_q[rd_ptr_q];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         streak_q   <= '0;
         reg_en_q   <= 1'b0;
         reg_addr_q <= '0;
         reg_data_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         streak_q   <= streak_d;
         reg_en_q   <= reg_en_d;
         reg_addr_q <= reg_addr_d;
         reg_data_q <= reg_data_d;
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr_q[wr_ptr_q] <= bus.copper_write_address;
         fifo_data_q[wr_ptr_q] <= bus.copper_write_data;
      end
   end

   assign bus.copper_write_ready = !fifo_full;
   assign bus.host_write_ready   = !force_copper;
   assign bus.reg_write_en       = reg_en_q;
   assign bus.reg_write_address  = reg_addr_q;
   assign bus.reg_write_data     = reg_data_q;
   assign copper_fifo_level      = count_q;

`ifdef VDP_REG_ARB_OVERFLOW_EN
`ifndef VDP_DEBUG_STOP
`define VDP_DEBUG_STOP $warning("vdp_reg_write_arbiter: copper write dropped")
`endif
   logic drop;
   logic overflow_q, overflow_d;

   assign drop = bus.copper_write_en && fifo_full;

   // A drop in the same cycle as a clear keeps the flag set.
   always_comb begin
      overflow_d = overflow_q;
      if (drop) begin
         overflow_d = 1'b1;
      end else if (overflow_clear) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= overflow_d;
      end
   end

   assign copper_overflow = overflow_q;

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (!reset && drop) begin
         `VDP_DEBUG_STOP;
      end
   end
`endif
`endif

endmodule
